// File: rtl/leds7_pkg.sv
// Shared types and constants for the UART-driven 7-segment display path.
package leds7_pkg;

  typedef enum logic {
    S_READY,
    S_PROC
  } state_t;

  localparam logic [7:0] ASCII_BS   = 8'h08;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_ESC  = 8'h1B;
  localparam logic [7:0] ASCII_BANG = 8'h21;

  // Active-high gfedcba patterns, index = hex value (entry 15 first).
  localparam logic [15:0][6:0] SEG7_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Returns {valid, nibble} for an ASCII hex character.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h61 && c <= 8'h66)
      r = {1'b1, 4'(c - 8'h57)};
    else if (c >= 8'h41 && c <= 8'h46)
      r = {1'b1, 4'(c - 8'h37)};
    return r;
  endfunction

endpackage

// File: rtl/uart_leds7_display_seg7_encoder.sv
// Nibble-to-segment encoder with blanking and selectable output polarity.
module seg7_encoder
  import leds7_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       en,
  output logic [6:0] seg
);

  logic [6:0] lit;

  // Look up the glyph, blank when disabled, then apply pin polarity.
  always_comb begin
    lit = en ? SEG7_LUT[nibble] : '0;
    seg = (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
  end

endmodule

// File: rtl/uart_leds7_display.sv
// UART byte stream to multi-digit 7-segment display controller.
module uart_leds7_display
  import leds7_pkg::*;
#(
  parameter int CLK_FREQ       = 50,
  parameter int NUM_DIGITS     = 4,
  parameter int BLINK_HZ       = 2,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [7:0]                        s_tdata,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  output logic [7*NUM_DIGITS-1:0]           seg,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_cnt,
  output logic                              blink_on,
  output logic                              err
);

  localparam int CNTW = $clog2(NUM_DIGITS + 1);
  localparam int DW   = 4 * NUM_DIGITS;
  localparam int HALF = CLK_FREQ * 1_000_000 / (2 * BLINK_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [7*NUM_DIGITS-1:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  state_t                 state;
  logic [7:0]             byte_r;
  logic [DW-1:0]          shadow;
  logic [DW-1:0]          disp;
  logic [DW-1:0]          nib_ext;
  logic [CNTW-1:0]        shadow_cnt;
  logic [4:0]             dec;
  logic                   toggle_evt;
  logic [CW-1:0]          blink_cnt;
  logic                   blink_phase;
  logic                   visible;
  logic [7*NUM_DIGITS-1:0] seg_next;

  // Decode the captured byte and flag a blink toggle for the timer.
  always_comb begin
    dec          = hex_to_nibble(byte_r);
    nib_ext      = '0;
    nib_ext[3:0] = dec[3:0];
    toggle_evt   = (state == S_PROC) && (byte_r == ASCII_BANG);
    visible      = !(blink_on && !blink_phase);
  end

  // Accept one byte, then spend one cycle applying it to the buffers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_READY;
      s_tready   <= 1'b1;
      byte_r     <= '0;
      shadow     <= '0;
      shadow_cnt <= '0;
      disp       <= '0;
      digit_cnt  <= '0;
      blink_on   <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_READY: begin
          if (s_tvalid) begin
            byte_r   <= s_tdata;
            state    <= S_PROC;
            s_tready <= 1'b0;
          end
        end
        S_PROC: begin
          state    <= S_READY;
          s_tready <= 1'b1;
          if (dec[4]) begin
            // Oldest digit falls off the top once the buffer is full.
            shadow <= (shadow << 4) | nib_ext;
            if (shadow_cnt != CNTW'(NUM_DIGITS))
              shadow_cnt <= shadow_cnt + CNTW'(1);
          end else begin
            case (byte_r)
              ASCII_BS: begin
                shadow <= shadow >> 4;
                if (shadow_cnt != '0)
                  shadow_cnt <= shadow_cnt - CNTW'(1);
              end
              ASCII_CR, ASCII_LF: begin
                disp      <= shadow;
                digit_cnt <= shadow_cnt;
              end
              ASCII_ESC: begin
                shadow     <= '0;
                shadow_cnt <= '0;
                disp       <= '0;
                digit_cnt  <= '0;
              end
              ASCII_BANG: blink_on <= ~blink_on;
              default:    err      <= 1'b1;
            endcase
          end
        end
      endcase
    end
  end

  // Free-running half-period timer; a blink toggle restarts it in the lit phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (toggle_evt) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == CW'(HALF - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + CW'(1);
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    seg7_encoder #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_enc (
      .nibble(disp[4*i +: 4]),
      .en    (visible && (digit_cnt > CNTW'(i))),
      .seg   (seg_next[7*i +: 7])
    );
  end

  // Register the segment pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      seg <= SEG_OFF;
    else
      seg <= seg_next;
  end

endmodule

// File: tb/tb_uart_leds7_display.sv
// Randomised self-checking bench for uart_leds7_display against a queue-based model.
module tb_uart_leds7_display;

  localparam int ND   = 4;
  localparam int HALF = 500;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [27:0] seg;
  logic [2:0]  digit_cnt;
  logic        blink_on;
  logic        err;

  always #5 clk = ~clk;

  uart_leds7_display #(
    .CLK_FREQ      (1),
    .NUM_DIGITS    (ND),
    .BLINK_HZ      (1000),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .seg      (seg),
    .digit_cnt(digit_cnt),
    .blink_on (blink_on),
    .err      (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int origin = 0;
  int sh[$];
  int disp[$];
  bit bon = 1'b0;

  // Active-high gfedcba glyphs for 0..F.
  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic bit phase_at(input int e);
    int n;
    n = e - origin;
    if (n < 0) return 1'b1;
    return ((n / HALF) % 2) == 0;
  endfunction

  // Expected segment pins just after edge e.
  function automatic logic [27:0] exp_seg(input int e);
    logic [27:0] r;
    bit vis;
    vis = !(bon && !phase_at(e - 1));
    r = '1;
    for (int i = 0; i < ND; i++)
      if (vis && i < disp.size()) r[7*i +: 7] = ~font[disp[i]];
    return r;
  endfunction

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  function automatic bit is_known(input logic [7:0] c);
    return hexval(c) >= 0 || c == 8'h08 || c == 8'h0D || c == 8'h0A ||
           c == 8'h1B || c == 8'h21;
  endfunction

  // Apply one accepted byte (accept edge k) to the model; returns 1 for junk.
  function automatic bit model_apply(input logic [7:0] c, input int k);
    int hv;
    hv = hexval(c);
    if (hv >= 0) begin
      sh.push_front(hv);
      if (sh.size() > ND) void'(sh.pop_back());
    end else if (c == 8'h08) begin
      if (sh.size() > 0) void'(sh.pop_front());
    end else if (c == 8'h0D || c == 8'h0A) begin
      disp = sh;
    end else if (c == 8'h1B) begin
      sh.delete();
      disp.delete();
    end else if (c == 8'h21) begin
      bon = !bon;
      origin = k + 1;
    end else begin
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic send(input logic [7:0] c);
    int w;
    int k;
    bit junk;
    s_tdata  = c;
    s_tvalid = 1'b1;
    w = 0;
    while (!s_tready && w < 8) begin
      tick();
      w++;
    end
    if (!s_tready) chk("tready_wait", 32'(s_tready), 32'd1);
    tick();
    k = cyc;
    s_tvalid = 1'b0;
    s_tdata  = 8'($urandom);
    junk = model_apply(c, k);
    chk("tready_low", 32'(s_tready), 32'd0);
    tick();
    chk("err_pulse", 32'(err), 32'(junk));
    chk("tready_back", 32'(s_tready), 32'd1);
    tick();
    chk("err_clear", 32'(err), 32'd0);
    chk("seg", 32'(seg), 32'(exp_seg(cyc)));
    chk("digit_cnt", 32'(digit_cnt), 32'(disp.size()));
    chk("blink_on", 32'(blink_on), 32'(bon));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      chk("seg_idle", 32'(seg), 32'(exp_seg(cyc)));
    end
  endtask

  // Four bytes with s_tvalid held high; data wiggles while not ready.
  task automatic stream(input logic [31:0] w4);
    logic [7:0] b;
    bit junk;
    s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = w4[31-8*i -: 8];
      s_tdata = b;
      chk("b2b_ready_hi", 32'(s_tready), 32'd1);
      tick();
      junk = model_apply(b, cyc);
      chk("b2b_ready_lo", 32'(s_tready), 32'd0);
      s_tdata = "3";
      tick();
    end
    s_tvalid = 1'b0;
    tick();
    tick();
    chk("b2b_seg", 32'(seg), 32'(exp_seg(cyc)));
    chk("b2b_cnt", 32'(digit_cnt), 32'(disp.size()));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] c;
    int r;

    repeat (3) tick();
    reset = 1'b0;
    origin = cyc;
    tick();
    chk("rst_seg", 32'(seg), 32'h0FFF_FFFF);
    chk("rst_cnt", 32'(digit_cnt), 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd1);
    chk("rst_blink", 32'(blink_on), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    send("1"); send("2"); send(8'h0D);
    chk("dir_12", 32'(seg), 32'({7'h7F, 7'h7F, 7'h79, 7'h24}));
    chk("dir_12_cnt", 32'(digit_cnt), 32'd2);

    send("A"); send("b"); send("0"); send("9"); send("F"); send(8'h0D);
    chk("dir_ovf", 32'(seg), 32'({7'h03, 7'h40, 7'h10, 7'h0E}));
    chk("dir_ovf_cnt", 32'(digit_cnt), 32'd4);

    send(8'h08); send(8'h0D);
    chk("dir_bs", 32'(seg), 32'({7'h7F, 7'h03, 7'h40, 7'h10}));
    chk("dir_bs_cnt", 32'(digit_cnt), 32'd3);
    send(8'h0D);
    chk("dir_cr_again", 32'(seg), 32'({7'h7F, 7'h03, 7'h40, 7'h10}));
    send(8'h1B);
    chk("dir_esc", 32'(seg), 32'h0FFF_FFFF);
    chk("dir_esc_cnt", 32'(digit_cnt), 32'd0);

    send("4"); send("5"); send(8'h0A);
    send("!");
    idle(1100);
    send("!");
    chk("blink_off", 32'(blink_on), 32'd0);
    idle(600);

    send("z");
    chk("junk_keep", 32'(seg), 32'({7'h7F, 7'h7F, 7'h19, 7'h12}));

    stream({"7", "8", "9", 8'h0D});

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    c = 8'("0" + $urandom_range(0, 9));
        2:       c = 8'("a" + $urandom_range(0, 5));
        3:       c = 8'("A" + $urandom_range(0, 5));
        4:       c = 8'h08;
        5:       c = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        6:       c = 8'h1B;
        7:       c = 8'h21;
        default: begin
          c = 8'($urandom);
          while (is_known(c)) c = 8'($urandom);
        end
      endcase
      send(c);
      idle($urandom_range(0, 5));
    end

    send("5"); send(8'h0D);
    s_tdata  = "6";
    s_tvalid = 1'b1;
    while (!s_tready) tick();
    tick();
    s_tvalid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_tready", 32'(s_tready), 32'd1);
    chk("mid_rst_cnt", 32'(digit_cnt), 32'd0);
    chk("mid_rst_seg", 32'(seg), 32'h0FFF_FFFF);
    chk("mid_rst_blink", 32'(blink_on), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    origin = cyc;
    sh.delete();
    disp.delete();
    bon = 1'b0;
    idle(3);
    send(8'h0D);
    chk("post_rst_cnt", 32'(digit_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
